call_request_queue: RTL and testbench

CALL_REQUEST_QUEUE -- requirements
Module: call_request_queue

---
 rtl/call_request_queue.sv | 92 +++++++++
 tb/tb_call_request_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/call_request_queue.sv
// call_request_queue: debounced floor-call switches feeding a first-word-fall-through request FIFO.
// Optional duplicate-call suppression when CALL_DEDUP_EN is defined.
module call_request_queue #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  SW,
    output logic        req_valid,
    output logic [3:0]  req_floor,
    input  logic        req_ready,
    output logic [15:0] pending,
    output logic [4:0]  count,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0] sync1, sync2, cand, stable, push_floor;
    logic [15:0] cnt;
    logic push, pop, full, dup, accept;
    logic [3:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, off;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            cand <= '0;
            stable <= '0;
            cnt <= '0;
            push <= 1'b0;
            push_floor <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt <= '0;
            end else if (cnt != 16'hffff) begin
                cnt <= cnt + 16'd1;
            end
            push <= cnt == 16'(DEBOUNCE_CYCLES - 1) && cand != stable;
            push_floor <= cand;
            if (cnt == 16'(DEBOUNCE_CYCLES - 1) && cand != stable)
                stable <= cand;
        end
    end

    assign req_valid = count != 5'd0;
    assign req_floor = req_valid ? mem[rptr] : 4'd0;
    assign pop = req_valid && req_ready;
    assign full = count == 5'(DEPTH);
`ifdef CALL_DEDUP_EN
    // With dedup at most one copy is queued, so popping that floor empties it.
    assign dup = pending[push_floor] && !(pop && req_floor == push_floor);
`else
    assign dup = 1'b0;
`endif
    assign accept = push && !dup && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            count <= count + 5'(accept) - 5'(pop);
            overflow <= overflow | (push && !dup && full && !pop);
        end
    end

    always_ff @(posedge clk)
        if (accept)
            mem[wptr] <= push_floor;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        pending = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rptr;
            if (5'(off) < count)
                pending[mem[i]] = 1'b1;
        end
    end
endmodule

// File: tb/tb_call_request_queue.sv
// tb_call_request_queue: directed stimulus with a scoreboard queue checked by a pop monitor.
module tb_call_request_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] SW = 4'd0;
    logic req_ready = 1'b0;
    logic req_valid;
    logic [3:0] req_floor;
    logic [15:0] pending;
    logic [4:0] count;
    logic overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;

    call_request_queue #(.DEBOUNCE_CYCLES(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .SW(SW), .req_valid(req_valid), .req_floor(req_floor),
        .req_ready(req_ready), .pending(pending), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic feed(input logic [3:0] f, input bit expect_push);
        SW = f;
        if (expect_push)
            exp_q.push_back(f);
        step(8);
    endtask

    task automatic drain();
        req_ready = 1'b1;
        for (int i = 0; i < 20 && count != 5'd0; i++)
            step(1);
        req_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(2);
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && req_valid && req_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL pop_order: got floor %0d expected none", req_floor);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (req_floor !== mon_exp) begin
                            miscompares++;
                            $display("FAIL pop_order: got floor %0d expected %0d", req_floor, mon_exp);
                        end
                    end
                end
            end
        join_none

        step(3);
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(req_valid), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_floor", 32'(req_floor), 32'd0);
        rst = 1'b0;
        step(10);
        check("sw0_no_call", 32'(count), 32'd0);

        SW = 4'd5;
        exp_q.push_back(4'd5);
        step(7);
        check("latency_not_early", 32'(req_valid), 32'd0);
        step(1);
        check("latency_valid", 32'(req_valid), 32'd1);
        check("latency_floor", 32'(req_floor), 32'd5);
        check("latency_pending", 32'(pending), 32'h0020);
        check("latency_count", 32'(count), 32'd1);
        req_ready = 1'b1;
        step(1);
        req_ready = 1'b0;
        check("single_pop_count", 32'(count), 32'd0);

        SW = 4'd0;
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            SW = (i % 2 == 0) ? 4'd3 : 4'd0;
            step(2);
        end
        step(8);
        check("bounce_count", 32'(count), 32'd0);
        check("bounce_valid", 32'(req_valid), 32'd0);

        feed(4'd1, 1'b1);
        feed(4'd2, 1'b1);
        feed(4'd3, 1'b1);
        feed(4'd4, 1'b1);
        feed(4'd6, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_head", 32'(req_floor), 32'd1);
        check("full_pending", 32'(pending), 32'h001e);
        drain();
        check("overflow_sticky", 32'(overflow), 32'd1);

        pulse_reset();
        exp_q.push_back(4'd6);
        step(8);
        check("post_reset_call", 32'(count), 32'd1);
        feed(4'd1, 1'b1);
        feed(4'd2, 1'b1);
        feed(4'd3, 1'b1);
        check("refill_count", 32'(count), 32'd4);
        check("refill_head", 32'(req_floor), 32'd6);
        SW = 4'd7;
        exp_q.push_back(4'd7);
        step(7);
        req_ready = 1'b1;
        step(1);
        req_ready = 1'b0;
        check("push_pop_full_count", 32'(count), 32'd4);
        check("push_pop_full_overflow", 32'(overflow), 32'd0);
        check("push_pop_full_pending", 32'(pending), 32'h008e);
        drain();

        SW = 4'd0;
        pulse_reset();
        feed(4'd2, 1'b1);
        feed(4'd5, 1'b1);
`ifdef CALL_DEDUP_EN
        feed(4'd2, 1'b0);
        check("dup_count", 32'(count), 32'd2);
`else
        feed(4'd2, 1'b1);
        check("dup_count", 32'(count), 32'd3);
`endif
        check("dup_overflow", 32'(overflow), 32'd0);
        drain();

        feed(4'd1, 1'b1);
        feed(4'd2, 1'b1);
        feed(4'd3, 1'b1);
        check("pre_reset_count", 32'(count), 32'd3);
        SW = 4'd9;
        step(2);
        rst = 1'b1;
        step(1);
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_pending", 32'(pending), 32'd0);
        check("midreset_overflow", 32'(overflow), 32'd0);
        check("midreset_valid", 32'(req_valid), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        exp_q.push_back(4'd9);
        step(10);
        check("after_reset_call", 32'(count), 32'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
